calc_op_scheduler: RTL

// - Sequences the calculator: debounces btn, latches signed 8-bit operands, issues one op
//   to the shared multi-cycle ALU via start/done handshake, converts result to 4 digits.
// - Sits between board switches/buttons and sevenSegments; owns digit regs bin0..bin3.

---
 rtl/calc_op_scheduler.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/calc_op_scheduler.sv
// rtl/calc_op_scheduler.sv - calculator sequencer: button debounce, ALU start/done handshake, BCD digits
// Optional feature macro: AUTO_REFRESH_EN (re-issue the last op when operands change while showing)
module calc_op_scheduler #(
  parameter int DEB_CYCLES = 1000000,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  btn,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        op_start,
  output logic [1:0]  op_code,
  output logic [7:0]  op_a,
  output logic [7:0]  op_b,
  input  logic        op_done,
  input  logic [15:0] op_result,
  input  logic        op_err,
  output logic        busy,
  output logic [3:0]  bin0,
  output logic [3:0]  bin1,
  output logic [3:0]  bin2,
  output logic [3:0]  bin3
);

  localparam int            DW       = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam int            TW       = $clog2(TIMEOUT + 2);
  localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CONV, SHOW} state_t;

  state_t        state, state_nxt;
  logic [4:0]    deb_level;
  logic [4:0]    press;
  logic [DW-1:0] deb_cnt [5];
  logic          op_press;
  logic [1:0]    sel_code;
  logic [TW-1:0] wcnt;
  logic [16:0]   res_ext;
  logic [16:0]   mag;
  logic          res_neg;
  logic          res_bad;
  logic [15:0]   dd_bcd;
  logic [15:0]   bcd_adj;
  logic [15:0]   bcd_nxt;
  logic [13:0]   dd_bin;
  logic [3:0]    dd_cnt;
  logic          cv_neg;
  logic          cv_bad;
  logic          do_latch;
  logic          do_refresh;
  logic          do_err;
  logic          do_capture;
  logic          do_show;

  // A level is accepted only after DEB_CYCLES consecutive samples that differ from the current one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_level <= '0;
      press     <= '0;
      for (int i = 0; i < 5; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        press[i] <= 1'b0;
        if (btn[i] == deb_level[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb_cnt[i]   <= '0;
          deb_level[i] <= btn[i];
          press[i]     <= btn[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  always_comb begin
    sel_code = 2'd0;
    if (press[1])      sel_code = 2'd0;
    else if (press[2]) sel_code = 2'd1;
    else if (press[3]) sel_code = 2'd2;
    else if (press[4]) sel_code = 2'd3;
  end

  assign op_press = |press[4:1];

  // 17-bit magnitude so that -32768 yields 32768 and lands in the error range
  assign res_ext = {op_result[15], op_result};
  assign mag     = op_result[15] ? (~res_ext + 17'd1) : res_ext;
  assign res_neg = op_result[15] & (mag != 17'd0);
  assign res_bad = (mag > 17'd9999) | (res_neg & (mag > 17'd999));

  always_comb begin
    bcd_adj = dd_bcd;
    for (int k = 0; k < 4; k++) begin
      if (dd_bcd[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = dd_bcd[4*k +: 4] + 4'd3;
    end
    bcd_nxt = {bcd_adj[14:0], dd_bin[13]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    do_latch   = 1'b0;
    do_refresh = 1'b0;
    do_err     = 1'b0;
    do_capture = 1'b0;
    do_show    = 1'b0;
    if (press[0]) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (op_press) begin
            state_nxt = ISSUE;
            do_latch  = 1'b1;
          end
        end
        ISSUE: state_nxt = WAIT;
        WAIT: begin
          if (op_done) begin
            if (op_err) begin
              state_nxt = SHOW;
              do_err    = 1'b1;
            end else begin
              state_nxt  = CONV;
              do_capture = 1'b1;
            end
          end else if (wcnt >= TMAX) begin
            state_nxt = SHOW;
            do_err    = 1'b1;
          end
        end
        CONV: begin
          if (cv_bad) begin
            state_nxt = SHOW;
            do_err    = 1'b1;
          end else if (dd_cnt == 4'd13) begin
            state_nxt = SHOW;
            do_show   = 1'b1;
          end
        end
        SHOW: begin
          if (op_press) begin
            state_nxt = ISSUE;
            do_latch  = 1'b1;
          end
`ifdef AUTO_REFRESH_EN
          else if ((a != op_a) || (b != op_b)) begin
            state_nxt  = ISSUE;
            do_refresh = 1'b1;
          end
`endif
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_code <= 2'd0;
      op_a    <= '0;
      op_b    <= '0;
      wcnt    <= '0;
      dd_bcd  <= '0;
      dd_bin  <= '0;
      dd_cnt  <= '0;
      cv_neg  <= 1'b0;
      cv_bad  <= 1'b0;
      {bin3, bin2, bin1, bin0} <= '0;
    end else begin
      if (do_latch) begin
        op_a    <= a;
        op_b    <= b;
        op_code <= sel_code;
      end else if (do_refresh) begin
        op_a <= a;
        op_b <= b;
      end
      wcnt <= (state == WAIT) ? wcnt + TW'(1) : '0;
      if (do_capture) begin
        dd_bcd <= '0;
        dd_bin <= mag[13:0];
        dd_cnt <= '0;
        cv_neg <= res_neg;
        cv_bad <= res_bad;
      end else if (state == CONV) begin
        dd_bcd <= bcd_nxt;
        dd_bin <= {dd_bin[12:0], 1'b0};
        dd_cnt <= dd_cnt + 4'd1;
      end
      if (press[0]) begin
        {bin3, bin2, bin1, bin0} <= '0;
      end else if (do_err) begin
        {bin3, bin2, bin1, bin0} <= 16'hEEEE;
      end else if (do_show) begin
        if (cv_neg) {bin3, bin2, bin1, bin0} <= {4'hF, bcd_nxt[11:0]};
        else        {bin3, bin2, bin1, bin0} <= bcd_nxt;
      end
    end
  end

  assign op_start = (state == ISSUE);
  assign busy     = (state == ISSUE) || (state == WAIT) || (state == CONV);

endmodule
